conv1_maxpool2x2: RTL and testbench
===================================

# conv1_maxpool2x2

Streaming 2×2/stride-2 max-pool stage between the first convolution core and the stage-2 convolution inside `cnn_top`. It consumes the conv1 feature-map stream, one pixel per `i_valid` beat, in raster order: 3 channels, 20-bit signed, 24×24. It emits the pooled 12×12×3 map in raster order, with coordinates and a frame-done pulse. There is no backpressure: the block accepts every beat and never stalls.

## Interface
- `CH`, default 3: channels per beat (conv1 CO).
- `I_BW`, default 20: bits per channel value, two's-complement signed.
- `IW`, default 24: input map width; must be even.
- `IH`, default 24: input map height; must be even.
- `OW`/`OH`, derived as IW/2, IH/2: output map size. Not overridable.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `i_clear`  in  1  synchronous frame abort; returns counters to (0,0).
- `i_valid`  in  1  input beat qualifier.
- `i_fmap`  in  CH*I_BW  channel c at bits [c*I_BW +: I_BW].
- `o_valid`  out  1  pooled-pixel qualifier; single-cycle pulse per output.
- `o_fmap`  out  CH*I_BW  pooled values, same packing as `i_fmap`.
- `o_x`  out  $clog2(OW)  output column of the current `o_valid`.
- `o_y`  out  $clog2(OH)  output row of the current `o_valid`.
- `o_frame_done`  out  1  asserted together with the `o_valid` for (OW-1, OH-1).

## Operation
- Counters `x_cnt` (0..IW-1) and `y_cnt` (0..IH-1) advance only on `i_valid`.
  - `x_cnt` wraps at IW-1 and increments `y_cnt`.
  - `y_cnt` wraps at IH-1 to 0. The next frame starts with no idle cycle required.
- Horizontal stage, per channel:
  - Even `x_cnt`: latch the input into `h_reg`.
  - Odd `x_cnt`: `hmax = smax(h_reg, input)`.
- Vertical stage, on odd `x_cnt`:
  - Even `y_cnt`: write `hmax` to line buffer entry `x_cnt>>1`. Nothing is emitted.
  - Odd `y_cnt`: `out = smax(linebuf[x_cnt>>1], hmax)`. Register `out` into `o_fmap`, pulse `o_valid`, set `o_x = x_cnt>>1` and `o_y = y_cnt>>1`.
- `smax` is a signed comparison. On a tie it returns the equal value. There is no ReLU in this block.
- Gaps of any length in `i_valid` are allowed. State holds across gaps.
- `i_clear` zeroes the counters and drops any partial window. A pending `o_valid` in the same cycle is still delivered. `i_clear` takes priority over a simultaneous `i_valid`; that beat is discarded.
- Line buffer contents are not cleared. They are always overwritten on an even row before they are read.

## Timing
- Latency: `o_valid` rises in the cycle after the rising edge that samples the odd-row, odd-column input beat. This is fixed at 1 cycle.
- Throughput: at most one output per 2 accepted beats within an odd input row. There are none on even rows. An output frame is 144 pulses per 576 accepted beats.
- `o_fmap`, `o_x` and `o_y` hold their last value when `o_valid` is low.
- `o_frame_done` is a 1-cycle pulse coincident with the final `o_valid` of the frame.
- Reset: all outputs are 0, counters are 0 and `h_reg` is 0. Reset asserted mid-frame aborts the frame. The first beat after release is pixel (0,0).
- The line buffer read is combinational (distributed RAM). A write and a read never hit the same entry in the same cycle.

## Structure
- Shared package `cnn_pkg`:
  - Constants `CONV1_CO=3`, `CONV1_OBW=20`, `CONV1_OUT_W=24`, `CONV1_OUT_H=24`, `POOL_OUT_W=12`, `POOL_OUT_H=12`.
  - Function `smax(a,b)`, parameterized by width via the caller's signed cast.
- Sub-module `pool_line_buf`:
  - OW entries × CH*I_BW bits.
  - 1 synchronous write port, 1 asynchronous read port, no reset on storage.
- Elaboration-time check: error if IW or IH is odd.

## Test plan
- **Ramp:** a full frame where pixel (x,y) channel c has value y*24+x+c*1000. Output (i,j) must equal (2j+1)*24+(2i+1)+c*1000. Expect 144 `o_valid` pulses; `o_frame_done` only on (11,11).
- **Negatives:** every value is -5 except -3 at (1,1) of each window. All outputs must be -3. With all values -5 the outputs must be -5 (signed comparison and tie behaviour).
- **Gaps:** the ramp frame with random 0–7 idle cycles between beats. Results must be identical to the ramp case, and every `o_valid` must be exactly 1 cycle after its odd/odd beat.
- **Back-to-back:** two consecutive frames with no gap. Expect 288 outputs. The second frame's (0,0) must be computed only from second-frame data.
- **Reset mid-frame:**
  - Assert `reset_n=0` at input (10,7). All outputs must read 0.
  - A fresh frame afterwards must produce correct ramp results.
  - Repeat with `i_clear` at (10,7) coincident with `i_valid`: that beat is dropped and the next beat is treated as (0,0).

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: constants and helpers shared across the cnn_top datapath.
//   CONV1_*  : geometry and word width of the conv1 output stream.
//   POOL_*   : pooled map size fed to the stage-2 convolution.
//   smax()   : signed max. Callers sign-extend their operands to 64 bits
//              with a signed cast and size-cast the result back to their
//              own width, so one function serves every datapath width.
package cnn_pkg;

    localparam int CONV1_CO    = 3;
    localparam int CONV1_OBW   = 20;
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int POOL_OUT_W  = 12;
    localparam int POOL_OUT_H  = 12;

    // Tie returns the (equal) value, so the operand choice does not matter.
    function automatic logic signed [63:0] smax(input logic signed [63:0] a,
                                                input logic signed [63:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: one row of horizontal-max results for the 2x2 pool.
//   clk            : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous read port (distributed RAM)
// Storage has no reset; every entry is rewritten on an even row before
// the following odd row reads it.
module pool_line_buf #(
    parameter int DEPTH = 12,
    parameter int AW    = 4,
    parameter int DW    = 60
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv1_maxpool2x2.sv
// conv1_maxpool2x2: streaming 2x2 / stride-2 signed max-pool on the conv1
// feature map. Accepts one pixel per i_valid beat in raster order, never
// stalls, emits one pooled pixel per 2x2 window one cycle after the
// window's bottom-right beat.
//   clk, reset_n   : clock, async active-low reset
//   i_clear        : synchronous frame abort (wins over i_valid)
//   i_valid/i_fmap : input beat, channel c at [c*I_BW +: I_BW]
//   o_valid/o_fmap : pooled pixel pulse and values, same packing
//   o_x, o_y       : pooled coordinates of the current o_valid
//   o_frame_done   : pulses with the last pooled pixel of the frame
module conv1_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int CH   = CONV1_CO,
    parameter int I_BW = CONV1_OBW,
    parameter int IW   = CONV1_OUT_W,
    parameter int IH   = CONV1_OUT_H
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_clear,
    input  logic                       i_valid,
    input  logic [CH*I_BW-1:0]         i_fmap,
    output logic                       o_valid,
    output logic [CH*I_BW-1:0]         o_fmap,
    output logic [$clog2(IW/2)-1:0]    o_x,
    output logic [$clog2(IH/2)-1:0]    o_y,
    output logic                       o_frame_done
);

    localparam int OW  = IW / 2;
    localparam int OH  = IH / 2;
    localparam int XW  = $clog2(IW);
    localparam int YW  = $clog2(IH);
    localparam int OXW = $clog2(OW);
    localparam int OYW = $clog2(OH);

    if ((IW % 2) != 0 || (IH % 2) != 0) begin : g_bad_dims
        $error("conv1_maxpool2x2: IW and IH must be even");
    end

    logic [XW-1:0]  x_cnt;
    logic [YW-1:0]  y_cnt;
    logic           beat, fire, lb_we, x_last, y_last;
    logic [OXW-1:0] x_half;
    logic [OYW-1:0] y_half;
    logic [CH-1:0][I_BW-1:0] in_v, h_reg, hmax, lb_rd, pool_v;

    assign in_v   = i_fmap;
    assign beat   = i_valid & ~i_clear;
    assign x_last = (x_cnt == XW'(IW - 1));
    assign y_last = (y_cnt == YW'(IH - 1));
    assign x_half = OXW'(x_cnt >> 1);
    assign y_half = OYW'(y_cnt >> 1);
    // Odd column closes a horizontal pair; the row parity picks store vs emit.
    assign lb_we  = beat & x_cnt[0] & ~y_cnt[0];
    assign fire   = beat & x_cnt[0] &  y_cnt[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_clear) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_valid) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Left pixel of each horizontal pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              h_reg <= '0;
        else if (beat && !x_cnt[0]) h_reg <= in_v;
    end

    always_comb begin
        hmax   = '0;
        pool_v = '0;
        for (int c = 0; c < CH; c++) begin
            hmax[c]   = I_BW'(smax(64'(signed'(h_reg[c])), 64'(signed'(in_v[c]))));
            pool_v[c] = I_BW'(smax(64'(signed'(lb_rd[c])), 64'(signed'(hmax[c]))));
        end
    end

    // Write (even row) and read (odd row) never coincide in one cycle.
    pool_line_buf #(
        .DEPTH (OW),
        .AW    (OXW),
        .DW    (CH * I_BW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (x_half),
        .wdata (hmax),
        .raddr (x_half),
        .rdata (lb_rd)
    );

    // A pending o_valid is not affected by i_clear; only reset drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_fmap       <= '0;
            o_x          <= '0;
            o_y          <= '0;
        end else begin
            o_valid      <= fire;
            o_frame_done <= fire & x_last & y_last;
            if (fire) begin
                o_fmap <= pool_v;
                o_x    <= x_half;
                o_y    <= y_half;
            end
        end
    end

endmodule

// File: tb/tb_conv1_maxpool2x2.sv
// Self-checking bench for conv1_maxpool2x2. Frames are built as plain
// pixel arrays; each expected pooled pixel is the max of its four source
// pixels, stamped with the cycle in which it must appear.
module tb_conv1_maxpool2x2;

    localparam int CH = 3, BW = 20, IW = 24, IH = 24, OW = 12, OH = 12;
    localparam int FW = CH * BW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_valid = 1'b0;
    logic [FW-1:0] i_fmap = '0;
    logic          o_valid, o_frame_done;
    logic [FW-1:0] o_fmap;
    logic [3:0]    o_x, o_y;

    conv1_maxpool2x2 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .i_fmap       (i_fmap),
        .o_valid      (o_valid),
        .o_fmap       (o_fmap),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int stray_done = 0;

    typedef struct {
        logic [FW-1:0] f;
        int            x;
        int            y;
        logic          done;
        int            cyc;
    } rec_t;

    rec_t mon_q[$];
    rec_t exp_q[$];
    int   pix[IH][IW][CH];

    always @(negedge clk) begin
        if (o_valid)
            mon_q.push_back('{o_fmap, int'(o_x), int'(o_y), o_frame_done, cyc});
        else if (o_frame_done && reset_n)
            stray_done++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_clear = 1'b0;
        end
    endtask

    // 0 ramp, 1 -5 with -3 at each window's (1,1), 2 all -5, 3 random
    task automatic fill(input int mode);
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++)
                for (int c = 0; c < CH; c++)
                    case (mode)
                        0: pix[y][x][c] = y * 24 + x + c * 1000;
                        1: pix[y][x][c] = (x % 2 == 1 && y % 2 == 1) ? -3 : -5;
                        2: pix[y][x][c] = -5;
                        default: pix[y][x][c] = int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
                    endcase
    endtask

    function automatic logic [FW-1:0] pack_px(input int y, input int x);
        logic [FW-1:0] v;
        int t;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            t = pix[y][x][c];
            v[c*BW +: BW] = t[BW-1:0];
        end
        return v;
    endfunction

    // Drives the first nbeats pixels of the current frame with random gaps.
    task automatic drive_frame(input int gapmax, input int nbeats);
        int y, x, m, t;
        rec_t e;
        for (int k = 0; k < nbeats; k++) begin
            y = k / IW;
            x = k % IW;
            repeat ($urandom_range(0, gapmax)) begin
                @(negedge clk);
                i_valid = 1'b0;
                i_clear = 1'b0;
                i_fmap  = FW'({$urandom(), $urandom()});
            end
            @(negedge clk);
            i_valid = 1'b1;
            i_clear = 1'b0;
            i_fmap  = pack_px(y, x);
            if (x % 2 == 1 && y % 2 == 1) begin
                e.f = '0;
                for (int c = 0; c < CH; c++) begin
                    m = pix[y-1][x-1][c];
                    if (pix[y-1][x][c] > m) m = pix[y-1][x][c];
                    if (pix[y][x-1][c] > m) m = pix[y][x-1][c];
                    if (pix[y][x][c]   > m) m = pix[y][x][c];
                    t = m;
                    e.f[c*BW +: BW] = t[BW-1:0];
                end
                e.x    = x / 2;
                e.y    = y / 2;
                e.done = (x / 2 == OW - 1) && (y / 2 == OH - 1);
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        rec_t a, e;
        idle(3);
        chk({tag, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
        chk({tag, "_stray_done"}, 64'(stray_done), 64'd0);
        while (mon_q.size() > 0 && exp_q.size() > 0) begin
            a = mon_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_fmap"}, 64'(a.f), 64'(e.f));
            chk({tag, "_xy_done"}, 64'({a.x[7:0], a.y[7:0], a.done}), 64'({e.x[7:0], e.y[7:0], e.done}));
            chk({tag, "_latency"}, 64'(a.cyc), 64'(e.cyc));
        end
        mon_q.delete();
        exp_q.delete();
        stray_done = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_o_fmap"}, 64'(o_fmap), 64'd0);
        chk({tag, "_o_x"}, 64'(o_x), 64'd0);
        chk({tag, "_o_y"}, 64'(o_y), 64'd0);
        chk({tag, "_o_done"}, 64'(o_frame_done), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Ramp
        fill(0);
        drive_frame(0, IW * IH);
        check_outputs("ramp");

        // Negatives: -3 wins over -5
        fill(1);
        drive_frame(0, IW * IH);
        check_outputs("neg3");

        // All ties at -5
        fill(2);
        drive_frame(0, IW * IH);
        check_outputs("neg5");

        // Ramp with random idle gaps
        fill(0);
        drive_frame(7, IW * IH);
        check_outputs("gaps");

        // Back-to-back random frames
        fill(3);
        drive_frame(0, IW * IH);
        fill(3);
        drive_frame(0, IW * IH);
        check_outputs("b2b");

        // Reset mid-frame after pixel (9,7)
        fill(0);
        drive_frame(0, 7 * IW + 10);
        check_outputs("pre_reset");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        idle(2);
        check_zero("mid_reset_hold");
        reset_n = 1'b1;
        drive_frame(0, IW * IH);
        check_outputs("post_reset");

        // i_clear together with the (10,7) beat; next beat is (0,0)
        fill(0);
        drive_frame(0, 7 * IW + 10);
        @(negedge clk);
        i_valid = 1'b1;
        i_clear = 1'b1;
        i_fmap  = pack_px(7, 10);
        fill(3);
        drive_frame(0, IW * IH);
        check_outputs("clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
